hazard_stall_ctrl: RTL

- Stall/flush controller for the 5-stage MIPS pipeline. It produces the enable and flush controls consumed by the F/D PC register, the F/D pipeline register and the D/E pipeline register.
- Detects RAW hazards by comparing Tuse against Tnew. Owns the multi-cycle mult/div busy countdown.
- Stalls F and D, and injects a bubble into E (D/E flush with enable held high), while any hazard is unresolved.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_if.sv | 47 ++++
 rtl/hazard_stall_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundles the hazard-detection inputs and pipeline-control outputs exchanged
//   between the pipeline datapath and the stall/flush controller.
//   master : pipeline side (drives D/E/M stage info, consumes controls)
//   slave  : controller side
//   Signals:
//     i_d_rs/i_d_rt, i_d_tuse_rs/i_d_tuse_rt, i_d_md_use : D-stage operand info
//     i_e_a3/i_e_tnew, i_m_a3/i_m_tnew                  : E/M producer info
//     i_e_md_start/i_e_md_is_div                        : MDU op start pulse
//     o_stall, o_pc_en, o_fd_en, o_de_en, o_de_flush     : pipeline controls
//     o_md_busy, o_stall_cnt                            : status / perf counter
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    logic [4:0]             i_d_rs;
    logic [4:0]             i_d_rt;
    logic [1:0]             i_d_tuse_rs;
    logic [1:0]             i_d_tuse_rt;
    logic                   i_d_md_use;
    logic [4:0]             i_e_a3;
    logic [1:0]             i_e_tnew;
    logic [4:0]             i_m_a3;
    logic [1:0]             i_m_tnew;
    logic                   i_e_md_start;
    logic                   i_e_md_is_div;
    logic                   o_stall;
    logic                   o_pc_en;
    logic                   o_fd_en;
    logic                   o_de_en;
    logic                   o_de_flush;
    logic                   o_md_busy;
    logic [STALL_CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_d_rs, i_d_rt, i_d_tuse_rs, i_d_tuse_rt, i_d_md_use,
               i_e_a3, i_e_tnew, i_m_a3, i_m_tnew, i_e_md_start, i_e_md_is_div,
        input  o_stall, o_pc_en, o_fd_en, o_de_en, o_de_flush, o_md_busy, o_stall_cnt
    );

    modport slave (
        input  i_d_rs, i_d_rt, i_d_tuse_rs, i_d_tuse_rt, i_d_md_use,
               i_e_a3, i_e_tnew, i_m_a3, i_m_tnew, i_e_md_start, i_e_md_is_div,
        output o_stall, o_pc_en, o_fd_en, o_de_en, o_de_flush, o_md_busy, o_stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Stall/flush controller for the 5-stage MIPS pipeline.
//   - RAW detection per D-stage source operand: stall while a producer in E or
//     M still needs more cycles (Tnew) than the consumer can wait (Tuse).
//   - Owns the mult/div busy countdown; MDU-using instructions wait in D.
//   - On stall: freeze PC and F/D, bubble D/E (flush with enable held high).
//   - Saturating count of stalled cycles.
//   Ports:
//     i_clk   : clock
//     i_reset : synchronous active-low reset
//     bus     : hazard_stall_ctrl_if.slave (stage info in, controls out)
// ----------------------------------------------------------------------------

// Per-operand RAW check against the E and M producers.
module hsc_raw_chk (
    input  logic [4:0] i_src,
    input  logic [1:0] i_tuse,
    input  logic [4:0] i_e_a3,
    input  logic [1:0] i_e_tnew,
    input  logic [4:0] i_m_a3,
    input  logic [1:0] i_m_tnew,
    output logic       o_stall
);
    logic w_e_hit;
    logic w_m_hit;

    // $zero is never a real dependency; Tuse=3 can never lose to Tnew<=2.
    assign w_e_hit = (i_src == i_e_a3) && (i_e_tnew > i_tuse);
    assign w_m_hit = (i_src == i_m_a3) && (i_m_tnew > i_tuse);
    assign o_stall = (i_src != 5'd0) && (w_e_hit || w_m_hit);
endmodule

module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int STALL_CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    hazard_stall_ctrl_if.slave   bus
);
    localparam int NUM_SRC = 2;
    localparam int MD_MAX  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(MD_MAX + 1);

    logic [NUM_SRC-1:0][4:0] w_src_addr;
    logic [NUM_SRC-1:0][1:0] w_src_tuse;
    logic [NUM_SRC-1:0]      w_src_stall;
    logic                    w_raw_stall;
    logic                    w_md_stall;
    logic                    w_md_busy;
    logic                    w_stall;

    logic [CNT_W-1:0]        r_md_cnt;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;

    assign w_src_addr = {bus.i_d_rt,      bus.i_d_rs};
    assign w_src_tuse = {bus.i_d_tuse_rt, bus.i_d_tuse_rs};

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            hsc_raw_chk u_chk (
                .i_src    (w_src_addr[g]),
                .i_tuse   (w_src_tuse[g]),
                .i_e_a3   (bus.i_e_a3),
                .i_e_tnew (bus.i_e_tnew),
                .i_m_a3   (bus.i_m_a3),
                .i_m_tnew (bus.i_m_tnew),
                .o_stall  (w_src_stall[g])
            );
        end
    endgenerate

    assign w_raw_stall = |w_src_stall;
    // Busy covers the start cycle itself, before the counter is loaded.
    assign w_md_busy   = bus.i_e_md_start | (r_md_cnt != '0);
    assign w_md_stall  = bus.i_d_md_use & w_md_busy;
    assign w_stall     = w_raw_stall | w_md_stall;

    // MDU countdown: a new start reloads even mid-countdown.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_md_cnt <= '0;
        end else if (bus.i_e_md_start) begin
            r_md_cnt <= bus.i_e_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
        end
    end

    // Stall performance counter, sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.o_stall     = w_stall;
    assign bus.o_pc_en     = ~w_stall;
    assign bus.o_fd_en     = ~w_stall;
    // D/E stays enabled so the flush actually loads a bubble.
    assign bus.o_de_en     = 1'b1;
    assign bus.o_de_flush  = w_stall;
    assign bus.o_md_busy   = w_md_busy;
    assign bus.o_stall_cnt = r_stall_cnt;
endmodule
